// File: rtl/aes_fifo_pkg.sv
// Shared widths and helpers for the AES-256 core's input (32->128) and output (128->32) FIFOs.
// WORD_W is the bus-side word, BLOCK_W the cipher-side block; neither is meant to be overridden.
package aes_fifo_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

  // Counter has to hold DEPTH_WORDS itself, hence one bit more than the address.
  function automatic int cnt_width(input int depth_words);
    return $clog2(depth_words) + 1;
  endfunction

endpackage

// File: rtl/fifo_data_in_if.sv
// Bus bundle between the word-side producer/block-side consumer and the 32->128 input FIFO.
// master drives pushes/pops/clear; slave (the FIFO) returns the head block and status.
interface fifo_data_in_if
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
);

  localparam int CW = cnt_width(DEPTH_WORDS);

  logic               clear;
  logic               write_fifo;
  logic [WORD_W-1:0]  data_in;
  logic               read_fifo;
  logic [BLOCK_W-1:0] data_out;
  logic               block_avail;
  logic               empty_fifo;
  logic               full_fifo;
  logic [CW-1:0]      counter_fifo;
  logic               overflow;
  logic               underflow;

  modport master (
    output clear, write_fifo, data_in, read_fifo,
    input  data_out, block_avail, empty_fifo, full_fifo, counter_fifo, overflow, underflow
  );

  modport slave (
    input  clear, write_fifo, data_in, read_fifo,
    output data_out, block_avail, empty_fifo, full_fifo, counter_fifo, overflow, underflow
  );

endinterface

// File: rtl/fifo_word_ram.sv
// Word store for the input FIFO: one synchronous write port, four asynchronous reads at raddr+0..3.
// Read is 0-cycle; no backpressure here, the caller decides when a write is accepted.
module fifo_word_ram
  import aes_fifo_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [WORD_W-1:0]  wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [BLOCK_W-1:0] rdata_o
);

  // Storage is deliberately not reset; only the pointers qualify it.
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Oldest word of the block goes to the top lane.
  for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_rd
    assign rdata_o[BLOCK_W-1-g*WORD_W -: WORD_W] = mem_q[raddr_i + AW'(g)];
  end

endmodule

// File: rtl/fifo_data_in.sv
// 32->128 input FIFO for the AES core: show-ahead head block on data_out (0-cycle), pop frees 4 words.
// Writes refused while full, pops refused without a full block; both set sticky error flags.
module fifo_data_in
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input logic           clk,
  input logic           resetn,
  fifo_data_in_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = cnt_width(DEPTH_WORDS);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               full, empty, avail;
  logic               wr_acc, rd_acc;
  logic [BLOCK_W-1:0] head_block;

  assign full  = (count_q == CW'(DEPTH_WORDS));
  assign empty = (count_q == '0);
  assign avail = (count_q >= CW'(WORDS_PER_BLOCK));

  // Full is judged before the edge, so a same-cycle pop never makes room for a push.
  assign wr_acc = bus.write_fifo && !full  && !bus.clear;
  assign rd_acc = bus.read_fifo  && avail  && !bus.clear;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(WORDS_PER_BLOCK);
      end
      count_d = count_q + CW'(wr_acc) - (rd_acc ? CW'(WORDS_PER_BLOCK) : CW'(0));
      if (bus.write_fifo && full) begin
        overflow_d = 1'b1;
      end
      if (bus.read_fifo && !avail) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_block)
  );

  assign bus.data_out     = head_block;
  assign bus.block_avail  = avail;
  assign bus.empty_fifo   = empty;
  assign bus.full_fifo    = full;
  assign bus.counter_fifo = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_data_in.sv
// Directed bench for fifo_data_in: expected blocks are queued on each pop request and
// checked by a separate negedge monitor; status outputs are checked inline.
module tb_fifo_data_in;

  localparam int DEPTH = 64;

  logic clk;
  logic resetn;

  fifo_data_in_if #(.DEPTH_WORDS(DEPTH)) bus ();

  fifo_data_in #(.DEPTH_WORDS(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop is presented when read_fifo meets block_avail before the edge.
  always @(negedge clk) begin
    if (resetn && bus.read_fifo && bus.block_avail && !bus.clear) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL block_pop: got %0h expected no block", bus.data_out);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          errors++;
          $display("FAIL block_pop: got %0h expected %0h", bus.data_out, e);
        end
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [31:0] d);
    bus.write_fifo = 1'b1;
    bus.data_in    = d;
    @(posedge clk); #1;
    bus.write_fifo = 1'b0;
  endtask

  task automatic rd();
    bus.read_fifo = 1'b1;
    @(posedge clk); #1;
    bus.read_fifo = 1'b0;
  endtask

  task automatic wrrd(input logic [31:0] d);
    bus.write_fifo = 1'b1;
    bus.read_fifo  = 1'b1;
    bus.data_in    = d;
    @(posedge clk); #1;
    bus.write_fifo = 1'b0;
    bus.read_fifo  = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
  endtask

  function automatic logic [127:0] blk(input logic [31:0] base);
    return {base, base + 32'd1, base + 32'd2, base + 32'd3};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn         = 1'b0;
    bus.clear      = 1'b0;
    bus.write_fifo = 1'b0;
    bus.read_fifo  = 1'b0;
    bus.data_in    = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("rst_cnt",   128'(bus.counter_fifo), 128'(0));
    chk("rst_empty", 128'(bus.empty_fifo),   128'(1));
    chk("rst_full",  128'(bus.full_fifo),    128'(0));

    // 1: asynchronous reset mid-stream, with underflow already set
    wr(32'h1111_0001); wr(32'h1111_0002); wr(32'h1111_0003);
    rd();
    chk("pre_rst_unf", 128'(bus.underflow),    128'(1));
    chk("pre_rst_cnt", 128'(bus.counter_fifo), 128'(3));
    #2 resetn = 1'b0;
    #1;
    chk("arst_cnt",   128'(bus.counter_fifo), 128'(0));
    chk("arst_empty", 128'(bus.empty_fifo),   128'(1));
    chk("arst_avail", 128'(bus.block_avail),  128'(0));
    chk("arst_ovf",   128'(bus.overflow),     128'(0));
    chk("arst_unf",   128'(bus.underflow),    128'(0));
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // 2: word ordering within a block
    wr(32'h0011_2233); wr(32'h4455_6677); wr(32'h8899_AABB);
    chk("ord_avail3", 128'(bus.block_avail), 128'(0));
    wr(32'hCCDD_EEFF);
    chk("ord_avail", 128'(bus.block_avail), 128'(1));
    chk("ord_head", bus.data_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    exp_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
    rd();
    chk("ord_cnt",   128'(bus.counter_fifo), 128'(0));
    chk("ord_empty", 128'(bus.empty_fifo),   128'(1));

    // 3: fill to 64, 65th write refused, drain in order
    for (int i = 0; i < 65; i++) wr(32'hA000_0000 + 32'(i));
    chk("fill_full", 128'(bus.full_fifo),    128'(1));
    chk("fill_cnt",  128'(bus.counter_fifo), 128'(64));
    chk("fill_ovf",  128'(bus.overflow),     128'(1));
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(blk(32'hA000_0000 + 32'(4 * k)));
      rd();
    end
    chk("drain_empty", 128'(bus.empty_fifo),   128'(1));
    chk("drain_cnt",   128'(bus.counter_fifo), 128'(0));
    chk("drain_unf",   128'(bus.underflow),    128'(0));
    do_reset();

    // 4: wrap - words 1..60, 15 blocks out, words 61..68 across the top of memory
    for (int i = 1; i <= 60; i++) wr(32'hB000_0000 + 32'(i));
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back(blk(32'hB000_0001 + 32'(4 * k)));
      rd();
    end
    for (int i = 61; i <= 68; i++) wr(32'hB000_0000 + 32'(i));
    chk("wrap_cnt8", 128'(bus.counter_fifo), 128'(8));
    chk("wrap_head", bus.data_out, 128'hB000003D_B000003E_B000003F_B0000040);
    exp_q.push_back(128'hB000003D_B000003E_B000003F_B0000040);
    rd();
    chk("wrap_cnt4", 128'(bus.counter_fifo), 128'(4));
    chk("wrap_head2", bus.data_out, 128'hB0000041_B0000042_B0000043_B0000044);
    exp_q.push_back(128'hB0000041_B0000042_B0000043_B0000044);
    rd();
    chk("wrap_cnt0", 128'(bus.counter_fifo), 128'(0));

    // 5: simultaneous write+read, then underflow with a partial block
    for (int i = 1; i <= 5; i++) wr(32'hC000_0000 + 32'(i));
    exp_q.push_back(128'hC0000001_C0000002_C0000003_C0000004);
    wrrd(32'hC000_0006);
    chk("sim_cnt",   128'(bus.counter_fifo), 128'(2));
    chk("sim_avail", 128'(bus.block_avail),  128'(0));
    wr(32'hC000_0007);
    rd();
    chk("unf_flag", 128'(bus.underflow),    128'(1));
    chk("unf_cnt",  128'(bus.counter_fifo), 128'(3));
    wr(32'hC000_0008);
    exp_q.push_back(128'hC0000005_C0000006_C0000007_C0000008);
    rd();
    chk("sim_cnt0", 128'(bus.counter_fifo), 128'(0));
    do_reset();

    // 6: full + read + write refuses the write; then clear with a write in the same cycle
    for (int i = 0; i < 64; i++) wr(32'hD000_0000 + 32'(i));
    exp_q.push_back(blk(32'hD000_0000));
    wrrd(32'hDEAD_BEEF);
    chk("fullrw_cnt", 128'(bus.counter_fifo), 128'(60));
    chk("fullrw_ovf", 128'(bus.overflow),     128'(1));
    for (int k = 1; k < 15; k++) begin
      exp_q.push_back(blk(32'hD000_0000 + 32'(4 * k)));
      rd();
    end
    chk("fullrw_head", bus.data_out, blk(32'hD000_003C));
    wr(32'hD100_0000); wr(32'hD100_0001); wr(32'hD100_0002);
    chk("clr_pre_cnt", 128'(bus.counter_fifo), 128'(7));
    bus.clear      = 1'b1;
    bus.write_fifo = 1'b1;
    bus.data_in    = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus.clear      = 1'b0;
    bus.write_fifo = 1'b0;
    chk("clr_cnt",   128'(bus.counter_fifo), 128'(0));
    chk("clr_ovf",   128'(bus.overflow),     128'(0));
    chk("clr_empty", 128'(bus.empty_fifo),   128'(1));
    for (int i = 0; i < 4; i++) wr(32'hE000_0000 + 32'(i));
    chk("clr_head", bus.data_out, blk(32'hE000_0000));
    exp_q.push_back(blk(32'hE000_0000));
    rd();
    chk("clr_cnt_end", 128'(bus.counter_fifo), 128'(0));

    @(posedge clk); #1;
    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
